// File: rtl/riscv_pkg.sv
// Shared RISC-V constants for the writeback slice: word width, register selector width,
// load funct3 encodings and the writeback source selector.
package riscv_pkg;
   localparam int XLEN  = 64;
   localparam int NREG  = 32;
   localparam int REG_W = $clog2(NREG);

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LD  = 3'b011;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_LWU = 3'b110;

   typedef enum logic [1:0] {
      SRC_NONE,
      SRC_MEM,
      SRC_FIFO,
      SRC_DIRECT
   } wb_src_e;
endpackage

// File: rtl/load_ext.sv
// Load lane select and sign/zero extension of a raw little-endian 64-bit memory word.
module load_ext
   import riscv_pkg::*;
(
   input  logic [2:0]      funct3,
   input  logic [2:0]      offset,
   input  logic [XLEN-1:0] word,
   output logic [XLEN-1:0] value
);
   logic [2:0]      lane;
   logic [XLEN-1:0] shifted;

   always_comb begin
      // offsets are forced down to the access size, so a misaligned request reads the aligned lane
      case (funct3[1:0])
         2'b00:   lane = offset;
         2'b01:   lane = {offset[2:1], 1'b0};
         2'b10:   lane = {offset[2], 2'b00};
         default: lane = 3'b000;
      endcase
      shifted = word >> {lane, 3'b000};
      case (funct3)
         F3_LB:   value = {{(XLEN-8){shifted[7]}},   shifted[7:0]};
         F3_LH:   value = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
         F3_LW:   value = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
         F3_LBU:  value = {{(XLEN-8){1'b0}},         shifted[7:0]};
         F3_LHU:  value = {{(XLEN-16){1'b0}},        shifted[15:0]};
         F3_LWU:  value = {{(XLEN-32){1'b0}},        shifted[31:0]};
         default: value = shifted;
      endcase
   end
endmodule

// File: rtl/wb_stage.sv
// Writeback arbiter: merges load responses and ALU results into one registered regfile write port.
// Define WB_LOAD_EXT_EN to build the load alignment/extension path; otherwise MemData is written as-is.
module wb_stage
   import riscv_pkg::*;
#(
   parameter int SIZE       = XLEN,
   parameter int N          = 32,
   parameter int ALU_DEPTH  = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic                       CLK,
   input  logic                       RST_N,
   input  logic                       MemValid,
   output logic                       MemReady,
   input  logic [$clog2(N)-1:0]       MemRd,
   input  logic [2:0]                 MemFunct3,
   input  logic [2:0]                 MemOff,
   input  logic [SIZE-1:0]            MemData,
   input  logic                       AluValid,
   output logic                       AluReady,
   input  logic [$clog2(N)-1:0]       AluRd,
   input  logic [SIZE-1:0]            AluData,
   output logic                       WE,
   output logic [$clog2(N)-1:0]       Rw,
   output logic [SIZE-1:0]            Din,
   output logic [$clog2(ALU_DEPTH):0] AluCount
);
   localparam int RW = $clog2(N);
   localparam int PW = $clog2(ALU_DEPTH);
   localparam int CW = PW + 1;
   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] DEPTH_C  = CW'(ALU_DEPTH);
   localparam logic [SW-1:0] STARVE_C = SW'(STARVE_MAX);

   logic [RW-1:0]   fifo_rd   [ALU_DEPTH];
   logic [SIZE-1:0] fifo_data [ALU_DEPTH];
   logic [PW-1:0]   wr_ptr, rd_ptr;
   logic [CW-1:0]   count;
   logic [SW-1:0]   starve;
   logic            active;

   logic            fifo_ne, starve_hit, alu_fire, enq, deq;
   wb_src_e         src;
   logic [RW-1:0]   sel_rd;
   logic [SIZE-1:0] sel_data, load_data;

`ifdef WB_LOAD_EXT_EN
   load_ext u_load_ext (
      .funct3 (MemFunct3),
      .offset (MemOff),
      .word   (MemData),
      .value  (load_data)
   );
`else
   logic unused_load_ctl;
   assign unused_load_ctl = ^{MemFunct3, MemOff};
   assign load_data       = MemData;
`endif

   assign fifo_ne    = (count != '0);
   assign starve_hit = fifo_ne && (starve == STARVE_C);
   assign MemReady   = !starve_hit;
   // active holds AluReady low through reset and releases it on the first edge afterwards
   assign AluReady   = active && (count < DEPTH_C);
   assign alu_fire   = AluValid && AluReady;
   assign AluCount   = count;

   always_comb begin
      src = SRC_NONE;
      if (starve_hit)    src = SRC_FIFO;
      else if (MemValid) src = SRC_MEM;
      else if (fifo_ne)  src = SRC_FIFO;
      else if (alu_fire) src = SRC_DIRECT;
   end

   assign deq = (src == SRC_FIFO);
   assign enq = alu_fire && (src != SRC_DIRECT);

   always_comb begin
      sel_rd   = '0;
      sel_data = '0;
      case (src)
         SRC_MEM:    begin sel_rd = MemRd;           sel_data = load_data;         end
         SRC_FIFO:   begin sel_rd = fifo_rd[rd_ptr]; sel_data = fifo_data[rd_ptr]; end
         SRC_DIRECT: begin sel_rd = AluRd;           sel_data = AluData;           end
         default:    ;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (enq) begin
         fifo_rd[wr_ptr]   <= AluRd;
         fifo_data[wr_ptr] <= AluData;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         active <= 1'b0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         starve <= '0;
         WE     <= 1'b0;
         Rw     <= '0;
         Din    <= '0;
      end else begin
         active <= 1'b1;
         if (enq) wr_ptr <= wr_ptr + PW'(1);
         if (deq) rd_ptr <= rd_ptr + PW'(1);
         if (enq && !deq)      count <= count + CW'(1);
         else if (deq && !enq) count <= count - CW'(1);
         if (deq || !fifo_ne)                             starve <= '0;
         else if (src == SRC_MEM && starve != STARVE_C)   starve <= starve + SW'(1);
         // x0 writes still consume their slot but never assert the write enable
         WE <= (src != SRC_NONE) && (sel_rd != '0);
         if (src != SRC_NONE) begin
            Rw  <= sel_rd;
            Din <= sel_data;
         end
      end
   end
endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus randomized traffic against a queue model.
module tb_wb_stage;
   localparam int DEPTH = 2;
   localparam int SMAX  = 4;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic        mem_valid = 1'b0, alu_valid = 1'b0;
   logic [4:0]  mem_rd = '0, alu_rd = '0;
   logic [2:0]  mem_f3 = 3'b011, mem_off = '0;
   logic [63:0] mem_data = '0, alu_data = '0;
   logic        mem_ready, alu_ready, we;
   logic [4:0]  rw;
   logic [63:0] din;
   logic [1:0]  alu_count;

   int checks = 0;
   int errors = 0;

   int unsigned q_rd[$];
   logic [63:0] q_data[$];
   int          starve;
   bit          active, exp_we, mem_acc, alu_acc;
   logic [4:0]  exp_rw;
   logic [63:0] exp_din;

   always #5 CLK = ~CLK;

   wb_stage dut (
      .CLK(CLK), .RST_N(RST_N),
      .MemValid(mem_valid), .MemReady(mem_ready), .MemRd(mem_rd),
      .MemFunct3(mem_f3), .MemOff(mem_off), .MemData(mem_data),
      .AluValid(alu_valid), .AluReady(alu_ready), .AluRd(alu_rd), .AluData(alu_data),
      .WE(we), .Rw(rw), .Din(din), .AluCount(alu_count)
   );

   function automatic logic [63:0] ext_model(input logic [2:0] f3, input logic [2:0] off,
                                             input logic [63:0] data);
      logic [63:0] v;
      v = data;
`ifdef WB_LOAD_EXT_EN
      begin
         int nb, lane;
         logic [63:0] mask;
         nb   = 1 << f3[1:0];
         lane = (int'(off) / nb) * nb;
         v    = data >> (8 * lane);
         if (nb < 8) begin
            mask = (64'd1 << (8 * nb)) - 64'd1;
            v    = v & mask;
            if (!f3[2] && v[8*nb-1]) v = v | ~mask;
         end
      end
`endif
      return v;
   endfunction

   task automatic model_reset();
      q_rd.delete();
      q_data.delete();
      starve  = 0;
      active  = 0;
      exp_we  = 0;
      exp_rw  = '0;
      exp_din = '0;
      mem_acc = 0;
      alu_acc = 0;
   endtask

   task automatic model_step();
      bit ne, hit, has, direct;
      int unsigned wrd;
      logic [63:0] wdata;
      ne      = (q_rd.size() != 0);
      hit     = ne && (starve == SMAX);
      alu_acc = alu_valid && active && (q_rd.size() < DEPTH);
      mem_acc = mem_valid && !hit;
      has = 1; direct = 0; wrd = 0; wdata = '0;
      if (hit || (!mem_valid && ne)) begin
         wrd = q_rd.pop_front(); wdata = q_data.pop_front(); starve = 0;
      end else if (mem_valid) begin
         wrd = mem_rd; wdata = ext_model(mem_f3, mem_off, mem_data);
         starve = ne ? starve + 1 : 0;
      end else if (alu_acc) begin
         wrd = alu_rd; wdata = alu_data; direct = 1; starve = 0;
      end else begin
         has = 0; starve = 0;
      end
      if (alu_acc && !direct) begin
         q_rd.push_back(alu_rd);
         q_data.push_back(alu_data);
      end
      exp_we = has && (wrd != 0);
      if (has) begin exp_rw = wrd[4:0]; exp_din = wdata; end
      active = 1;
   endtask

   task automatic cyc();
      model_step();
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic test_reset();
      model_reset();
      RST_N = 1'b0; alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 64'h77;
      repeat (3) @(negedge CLK);
      checks++; if (we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", we); end
      checks++; if (rw !== 5'd0) begin errors++; $display("FAIL reset_rw: got %0d expected 0", rw); end
      checks++; if (din !== 64'd0) begin errors++; $display("FAIL reset_din: got %h expected 0", din); end
      checks++; if (alu_ready !== 1'b0) begin errors++; $display("FAIL reset_alu_ready: got %b expected 0", alu_ready); end
      checks++; if (alu_count !== 2'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", alu_count); end
      RST_N = 1'b1;
      cyc();
      checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL release_alu_ready: got %b expected 1", alu_ready); end
      checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL release_mem_ready: got %b expected 1", mem_ready); end
      checks++; if (we !== 1'b0) begin errors++; $display("FAIL release_we: got %b expected 0", we); end
      alu_valid = 1'b0;
   endtask

   task automatic test_lone_alu();
      alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'h1234;
      cyc();
      alu_valid = 1'b0;
      checks++; if ({we, rw} !== {1'b1, 5'd5}) begin errors++; $display("FAIL lone_alu_rw: got we=%b rw=%0d expected we=1 rw=5", we, rw); end
      checks++; if (din !== 64'h1234) begin errors++; $display("FAIL lone_alu_din: got %h expected 1234", din); end
      checks++; if (alu_count !== 2'd0) begin errors++; $display("FAIL lone_alu_count: got %0d expected 0", alu_count); end
      cyc();
      checks++; if (we !== 1'b0) begin errors++; $display("FAIL lone_alu_idle: got we=%b expected 0", we); end
   endtask

   task automatic test_load_ext();
      logic [63:0] e_lb, e_lhu;
`ifdef WB_LOAD_EXT_EN
      e_lb = 64'hFFFF_FFFF_FFFF_FF80; e_lhu = 64'h0000_0000_0000_BEEF;
`else
      e_lb = 64'h0000_0000_8000_0000; e_lhu = 64'hBEEF_0000_0000_0000;
`endif
      mem_valid = 1'b1; mem_rd = 5'd9; mem_f3 = 3'b000; mem_off = 3'd3; mem_data = 64'h0000_0000_8000_0000;
      cyc();
      checks++; if ({we, rw} !== {1'b1, 5'd9}) begin errors++; $display("FAIL load_lb_rw: got we=%b rw=%0d expected we=1 rw=9", we, rw); end
      checks++; if (din !== e_lb) begin errors++; $display("FAIL load_lb_din: got %h expected %h", din, e_lb); end
      mem_rd = 5'd10; mem_f3 = 3'b101; mem_off = 3'd6; mem_data = 64'hBEEF_0000_0000_0000;
      cyc();
      mem_valid = 1'b0;
      checks++; if (din !== e_lhu) begin errors++; $display("FAIL load_lhu_din: got %h expected %h", din, e_lhu); end
   endtask

   task automatic test_collision();
      mem_valid = 1'b1; mem_rd = 5'd3; mem_f3 = 3'b011; mem_off = 3'd0; mem_data = 64'hA5A5_0000_1111_2222;
      alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 64'h4444;
      cyc();
      mem_valid = 1'b0; alu_valid = 1'b0;
      checks++; if ({we, rw} !== {1'b1, 5'd3}) begin errors++; $display("FAIL collide_first: got we=%b rw=%0d expected rw=3", we, rw); end
      checks++; if (din !== 64'hA5A5_0000_1111_2222) begin errors++; $display("FAIL collide_mem_din: got %h expected a5a5000011112222", din); end
      checks++; if (alu_count !== 2'd1) begin errors++; $display("FAIL collide_count: got %0d expected 1", alu_count); end
      cyc();
      checks++; if ({we, rw} !== {1'b1, 5'd4}) begin errors++; $display("FAIL collide_second: got we=%b rw=%0d expected rw=4", we, rw); end
      checks++; if (din !== 64'h4444) begin errors++; $display("FAIL collide_alu_din: got %h expected 4444", din); end
      checks++; if (alu_count !== 2'd0) begin errors++; $display("FAIL collide_drain: got %0d expected 0", alu_count); end
   endtask

   task automatic test_starvation();
      int k;
      bit acc, exp_mr;
      logic [4:0] rexp;
      k = 0;
      for (int i = 0; i < 14; i++) begin
         exp_mr = !(i == 5 || i == 10);
         checks++; if (mem_ready !== exp_mr) begin errors++; $display("FAIL starve_ready[%0d]: got %b expected %b", i, mem_ready, exp_mr); end
         mem_valid = 1'b1; mem_rd = 5'(16 + k); mem_f3 = 3'b011; mem_off = 3'd0; mem_data = {32'hC0DE0000, 32'(k)};
         alu_valid = (i < 2); alu_rd = 5'(10 + i); alu_data = 64'hA000 + 64'(i);
         acc = mem_ready;
         cyc();
         rexp = (i == 5) ? 5'd10 : (i == 10) ? 5'd11 : 5'(16 + k);
         checks++; if ({we, rw} !== {1'b1, rexp}) begin errors++; $display("FAIL starve_write[%0d]: got we=%b rw=%0d expected rw=%0d", i, we, rw, rexp); end
         if (acc) k++;
      end
      mem_valid = 1'b0; alu_valid = 1'b0;
      checks++; if (alu_count !== 2'd0) begin errors++; $display("FAIL starve_empty: got %0d expected 0", alu_count); end
   endtask

   task automatic test_x0_full();
      int idx, nseen;
      int seen[3];
      bit acc;
      alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 64'd77;
      cyc();
      alu_valid = 1'b0;
      checks++; if (we !== 1'b0) begin errors++; $display("FAIL x0_drop: got we=%b expected 0", we); end
      checks++; if (alu_count !== 2'd0) begin errors++; $display("FAIL x0_count: got %0d expected 0", alu_count); end
      idx = 0; nseen = 0;
      for (int i = 0; i < 24; i++) begin
         mem_valid = (i < 20); mem_rd = 5'd8; mem_f3 = 3'b011; mem_off = 3'd0; mem_data = 64'(i);
         alu_valid = (idx < 3); alu_rd = 5'(20 + idx); alu_data = 64'hD00 + 64'(idx);
         checks++; if (alu_ready !== (q_rd.size() < DEPTH)) begin errors++; $display("FAIL full_ready[%0d]: got %b expected %b", i, alu_ready, q_rd.size() < DEPTH); end
         if (i == 2) begin
            checks++; if (alu_ready !== 1'b0) begin errors++; $display("FAIL full_blocked: got %b expected 0", alu_ready); end
         end
         acc = alu_valid && alu_ready;
         cyc();
         if (acc) idx++;
         if (we && rw >= 5'd20 && rw <= 5'd22) begin
            if (nseen < 3) seen[nseen] = int'(rw);
            nseen++;
         end
      end
      mem_valid = 1'b0; alu_valid = 1'b0;
      checks++; if (nseen !== 3) begin errors++; $display("FAIL full_lost: got %0d alu writes expected 3", nseen); end
      for (int j = 0; j < 3; j++) begin
         checks++; if (seen[j] !== 20 + j) begin errors++; $display("FAIL full_order[%0d]: got rd %0d expected %0d", j, seen[j], 20 + j); end
      end
   endtask

   task automatic test_random();
      mem_valid = 1'b0; alu_valid = 1'b0; mem_acc = 0; alu_acc = 0;
      for (int c = 0; c < 400; c++) begin
         checks++; if (alu_count !== 2'(q_rd.size())) begin errors++; $display("FAIL rnd_count[%0d]: got %0d expected %0d", c, alu_count, q_rd.size()); end
         checks++; if (mem_ready !== !(q_rd.size() != 0 && starve == SMAX)) begin errors++; $display("FAIL rnd_mem_ready[%0d]: got %b", c, mem_ready); end
         checks++; if (alu_ready !== (q_rd.size() < DEPTH)) begin errors++; $display("FAIL rnd_alu_ready[%0d]: got %b", c, alu_ready); end
         if (!(mem_valid && !mem_acc)) begin
            mem_valid = ($urandom_range(0, 99) < 60);
            mem_rd = 5'($urandom_range(0, 31)); mem_f3 = 3'($urandom_range(0, 7)); mem_off = 3'($urandom_range(0, 7));
            mem_data = {$urandom, $urandom};
         end
         if (!(alu_valid && !alu_acc)) begin
            alu_valid = ($urandom_range(0, 99) < 50);
            alu_rd = 5'($urandom_range(0, 31)); alu_data = {$urandom, $urandom};
         end
         cyc();
         checks++; if (we !== exp_we) begin errors++; $display("FAIL rnd_we[%0d]: got %b expected %b", c, we, exp_we); end
         if (exp_we) begin
            checks++; if (rw !== exp_rw) begin errors++; $display("FAIL rnd_rw[%0d]: got %0d expected %0d", c, rw, exp_rw); end
            checks++; if (din !== exp_din) begin errors++; $display("FAIL rnd_din[%0d]: got %h expected %h", c, din, exp_din); end
         end
      end
      mem_valid = 1'b0; alu_valid = 1'b0;
      repeat (8) cyc();
   endtask

   task automatic test_reset_mid();
      mem_valid = 1'b1; mem_rd = 5'd8; mem_f3 = 3'b011; mem_off = 3'd0; mem_data = 64'h55;
      alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 64'hC12;
      cyc();
      alu_rd = 5'd13; alu_data = 64'hC13;
      cyc();
      mem_valid = 1'b0; alu_valid = 1'b0;
      checks++; if (we !== 1'b1) begin errors++; $display("FAIL mid_pre_we: got %b expected 1", we); end
      checks++; if (alu_count !== 2'd2) begin errors++; $display("FAIL mid_pre_count: got %0d expected 2", alu_count); end
      #2 RST_N = 1'b0;
      #1;
      checks++; if (we !== 1'b0) begin errors++; $display("FAIL mid_we_async: got %b expected 0", we); end
      checks++; if (alu_count !== 2'd0) begin errors++; $display("FAIL mid_count: got %0d expected 0", alu_count); end
      checks++; if (alu_ready !== 1'b0) begin errors++; $display("FAIL mid_alu_ready: got %b expected 0", alu_ready); end
      model_reset();
      @(negedge CLK);
      RST_N = 1'b1;
      cyc();
      cyc();
      checks++; if (we !== 1'b0) begin errors++; $display("FAIL mid_stale_write: got we=%b rw=%0d expected no write", we, rw); end
      checks++; if (alu_count !== 2'd0) begin errors++; $display("FAIL mid_after_count: got %0d expected 0", alu_count); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_lone_alu();
      test_load_ext();
      test_collision();
      test_starvation();
      test_x0_full();
      test_random();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
